// File: rtl/fp_minmax_pkg.sv
// Shared types, status bit positions and IEEE-754 classification helpers for the min/max reducer.
// Latency: combinational helpers only, no state.
// Backpressure: not applicable, no flow control here.
package fp_minmax_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // Positions of the exception flags in the {NV,DZ,OF,UF,NX} status word
  localparam int ST_NV = 4;
  localparam int ST_DZ = 3;
  localparam int ST_OF = 2;
  localparam int ST_UF = 1;
  localparam int ST_NX = 0;

  // Helpers take the operand zero-extended to this width, plus the format's field widths
  localparam int FP_MAX_W = 64;

  function automatic logic is_nan(input logic [FP_MAX_W-1:0] x, input int expo_w, input int mant_w);
    logic [FP_MAX_W-1:0] mant_mask;
    logic [FP_MAX_W-1:0] expo_mask;
    mant_mask = (64'd1 << mant_w) - 64'd1;
    expo_mask = ((64'd1 << expo_w) - 64'd1) << mant_w;
    return ((x & expo_mask) == expo_mask) && ((x & mant_mask) != '0);
  endfunction

  // Signalling NaN: NaN with the quiet bit (mantissa MSB) clear
  function automatic logic is_snan(input logic [FP_MAX_W-1:0] x, input int expo_w, input int mant_w);
    return is_nan(x, expo_w, mant_w) && !x[mant_w-1];
  endfunction

  // Sign 0, exponent all-ones, only the quiet bit set in the mantissa
  function automatic logic [FP_MAX_W-1:0] canonical_qnan(input int expo_w, input int mant_w);
    return (((64'd1 << expo_w) - 64'd1) << mant_w) | (64'd1 << (mant_w - 1));
  endfunction

endpackage

// File: rtl/fp_minmax_cmp.sv
// Ordering of two IEEE-754 operands under minimumNumber/maximumNumber rules.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle from the current accumulator and incoming beat.
module fp_minmax_cmp
  import fp_minmax_pkg::*;
#(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  localparam int DATA_W = 1 + EXPO_W + MANT_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              op_max,
  output logic              b_wins,
  output logic              both_nan,
  output logic              any_snan
);

  logic a_nan;
  logic b_nan;
  logic a_lt_b;
  logic b_lt_a;
  logic a_sign;
  logic b_sign;
  logic [DATA_W-2:0] a_mag;
  logic [DATA_W-2:0] b_mag;

  assign a_nan    = is_nan(FP_MAX_W'(a), EXPO_W, MANT_W);
  assign b_nan    = is_nan(FP_MAX_W'(b), EXPO_W, MANT_W);
  assign both_nan = a_nan && b_nan;
  assign any_snan = is_snan(FP_MAX_W'(a), EXPO_W, MANT_W) || is_snan(FP_MAX_W'(b), EXPO_W, MANT_W);
  assign a_sign   = a[DATA_W-1];
  assign b_sign   = b[DATA_W-1];
  assign a_mag    = a[DATA_W-2:0];
  assign b_mag    = b[DATA_W-2:0];

  // Sign-magnitude ordering (-0 below +0, Inf and subnormals fall out naturally), then NaN-avoiding pick; ties keep a
  always_comb begin
    a_lt_b = 1'b0;
    b_lt_a = 1'b0;
    b_wins = 1'b0;
    if (a_sign != b_sign) begin
      a_lt_b = a_sign;
      b_lt_a = b_sign;
    end else if (!a_sign) begin
      a_lt_b = a_mag < b_mag;
      b_lt_a = b_mag < a_mag;
    end else begin
      a_lt_b = a_mag > b_mag;
      b_lt_a = b_mag > a_mag;
    end
    if (a_nan && !b_nan) begin
      b_wins = 1'b1;
    end else if (!a_nan && !b_nan) begin
      b_wins = op_max ? a_lt_b : b_lt_a;
    end
  end

endmodule

// File: rtl/fp_minmax_reduce.sv
// Streaming IEEE-754 minimumNumber/maximumNumber reduction with sticky NV and saturating element count.
// Latency: out_valid rises one cycle after the last beat is accepted; one beat per cycle within a packet.
// Backpressure: in_ready drops while a result waits in DONE; out_ready low holds the result stable.
// Optional: define FP_MINMAX_IDX_EN to add out_idx, the zero-based index of the winning beat.
module fp_minmax_reduce
  import fp_minmax_pkg::*;
#(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  parameter int CNT_W  = 8,
  localparam int DATA_W = 1 + EXPO_W + MANT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              op_max,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_status,
  output logic [CNT_W-1:0]  out_cnt
`ifdef FP_MINMAX_IDX_EN
  ,
  output logic [CNT_W-1:0]  out_idx
`endif
);

  localparam logic [DATA_W-1:0] QNAN = DATA_W'(canonical_qnan(EXPO_W, MANT_W));

  state_t              state_q;
  state_t              state_d;
  logic [DATA_W-1:0]   acc_q;
  logic                mode_q;
  logic                nv_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                beat;
  logic                b_wins;
  logic                both_nan;
  logic                any_snan;

  assign beat = in_valid && in_ready;

  fp_minmax_cmp #(
    .EXPO_W (EXPO_W),
    .MANT_W (MANT_W)
  ) u_cmp (
    .a        (acc_q),
    .b        (in_data),
    .op_max   (mode_q),
    .b_wins   (b_wins),
    .both_nan (both_nan),
    .any_snan (any_snan)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs: accept beats until last, then hold the result until taken
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        if (beat) state_d = in_last ? DONE : ACCUM;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Accumulator, mode, sticky NV and counter; a NaN is stored canonicalised so a lone NaN emerges as qNaN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      mode_q <= 1'b0;
      nv_q   <= 1'b0;
      cnt_q  <= '0;
    end else if (beat) begin
      if (state_q == IDLE) begin
        acc_q  <= is_nan(FP_MAX_W'(in_data), EXPO_W, MANT_W) ? QNAN : in_data;
        mode_q <= op_max;
        nv_q   <= is_snan(FP_MAX_W'(in_data), EXPO_W, MANT_W);
        cnt_q  <= CNT_W'(1);
      end else begin
        if (b_wins)        acc_q <= in_data;
        else if (both_nan) acc_q <= QNAN;
        nv_q  <= nv_q || any_snan;
        cnt_q <= (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end
    end
  end

`ifdef FP_MINMAX_IDX_EN
  logic [CNT_W-1:0] idx_q;

  // Winning beat index; the pre-increment count is this beat's index and saturates along with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (beat) begin
      if (state_q == IDLE) idx_q <= '0;
      else if (b_wins)     idx_q <= cnt_q;
    end
  end

  assign out_idx = idx_q;
`endif

  // Result fields come straight from registers, so they are stable for the whole DONE wait
  always_comb begin
    out_status        = '0;
    out_status[ST_NV] = nv_q;
  end

  assign out_data = acc_q;
  assign out_cnt  = cnt_q;

endmodule

// File: tb/tb_fp_minmax_reduce.sv
module tb_fp_minmax_reduce;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        op_max;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_status;
  logic [7:0]  out_cnt;
  logic [7:0]  out_idx_obs;
`ifdef FP_MINMAX_IDX_EN
  logic [7:0]  out_idx;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_minmax_reduce dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .op_max     (op_max),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_status (out_status),
    .out_cnt    (out_cnt)
`ifdef FP_MINMAX_IDX_EN
    ,
    .out_idx    (out_idx)
`endif
  );

`ifdef FP_MINMAX_IDX_EN
  assign out_idx_obs = out_idx;
`else
  assign out_idx_obs = 8'd0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Total order over non-NaN fp32 values as unsigned keys: negatives flipped, positives offset above them
  function automatic logic [31:0] order_key(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic bit f_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Reference reduction: skip NaNs, keep the earliest extreme, all-NaN gives canonical qNaN at index 0
  function automatic void model(input logic [31:0] ops[$], input bit mx,
                                output logic [31:0] d, output logic [4:0] st,
                                output logic [7:0] cnt, output logic [7:0] idx);
    bit found = 0;
    bit nv = 0;
    d = 32'h7FC0_0000;
    idx = 8'd0;
    foreach (ops[i]) begin
      if (f_is_nan(ops[i])) begin
        if (!ops[i][22]) nv = 1;
      end else if (!found || (mx ? (order_key(ops[i]) > order_key(d))
                                 : (order_key(ops[i]) < order_key(d)))) begin
        d = ops[i];
        idx = (i > 255) ? 8'd255 : 8'(i);
        found = 1;
      end
    end
    st = {nv, 4'b0000};
    cnt = (ops.size() > 255) ? 8'd255 : 8'(ops.size());
  endfunction

  // Drive one packet back to back, check latency, results, stall behaviour and handshake
  task automatic run_pkt(input logic [31:0] ops[$], input bit mx, input bit mx_rest, input int stall,
                         output logic [31:0] o_data, output logic [4:0] o_st,
                         output logic [7:0] o_cnt, output logic [7:0] o_idx);
    logic [31:0] ed;
    logic [4:0]  es;
    logic [7:0]  ec;
    logic [7:0]  ei;
    model(ops, mx, ed, es, ec, ei);
    check("idle_in_ready", in_ready, 1);
    foreach (ops[i]) begin
      in_valid = 1'b1;
      in_data  = ops[i];
      in_last  = (i == ops.size() - 1);
      op_max   = (i == 0) ? mx : mx_rest;
      if (in_last) check("no_early_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("out_valid_after_last", out_valid, 1);
    check("out_data", out_data, ed);
    check("out_status", out_status, es);
    check("out_cnt", out_cnt, ec);
`ifdef FP_MINMAX_IDX_EN
    check("out_idx", out_idx, ei);
`endif
    o_data = out_data;
    o_st   = out_status;
    o_cnt  = out_cnt;
    o_idx  = out_idx_obs;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_data", out_data, ed);
      check("stall_out_cnt", out_cnt, ec);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_hs_out_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] q[$];
    logic [31:0] pool[$];
    logic [31:0] rd;
    logic [4:0]  rs;
    logic [7:0]  rc;
    logic [7:0]  ri;
    int          len;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; op_max = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_status", out_status, 0);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_out_idx", out_idx_obs, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic min packet
    q = '{32'h3F80_0000, 32'hC000_0000, 32'h4040_0000};
    run_pkt(q, 1'b0, 1'b0, 0, rd, rs, rc, ri);
    check("min3_data", rd, 32'hC000_0000);
    check("min3_status", rs, 0);
    check("min3_cnt", rc, 3);

    // Signed zeros
    q = '{32'h8000_0000, 32'h0000_0000};
    run_pkt(q, 1'b1, 1'b1, 0, rd, rs, rc, ri);
    check("max_zero", rd, 32'h0000_0000);
    run_pkt(q, 1'b0, 1'b0, 1, rd, rs, rc, ri);
    check("min_zero", rd, 32'h8000_0000);

    // NaN handling and sticky NV
    q = '{32'h7FC0_0000, 32'h3F80_0000, 32'h7F80_0001};
    run_pkt(q, 1'b0, 1'b0, 0, rd, rs, rc, ri);
    check("nan_mix_data", rd, 32'h3F80_0000);
    check("nan_mix_status", rs, 5'b10000);
    q = '{32'h7FC0_0001};
    run_pkt(q, 1'b0, 1'b0, 0, rd, rs, rc, ri);
    check("lone_qnan_data", rd, 32'h7FC0_0000);
    check("lone_qnan_status", rs, 0);

    // op_max only sampled on the first beat
    q = '{32'h0000_0001, 32'h7F80_0000};
    run_pkt(q, 1'b1, 1'b0, 0, rd, rs, rc, ri);
    check("mode_held", rd, 32'h7F80_0000);

    // Backpressure in DONE, then immediate next packet
    q = '{32'h4000_0000, 32'h3F80_0000};
    run_pkt(q, 1'b1, 1'b1, 5, rd, rs, rc, ri);
    check("stall_result", rd, 32'h4000_0000);

    // Tie: earliest index wins
    q = '{32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000};
    run_pkt(q, 1'b0, 1'b0, 0, rd, rs, rc, ri);
    check("tie_data", rd, 32'h3F80_0000);
`ifdef FP_MINMAX_IDX_EN
    check("tie_idx", ri, 1);
`endif

    // Reset in the middle of a packet discards its elements
    in_valid = 1'b1; in_data = 32'hFF80_0000; in_last = 1'b0; op_max = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_cnt", out_cnt, 0);
    check("midrst_out_data", out_data, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_no_result", out_valid, 0);
    q = '{32'h3F80_0000, 32'h4000_0000};
    run_pkt(q, 1'b0, 1'b0, 0, rd, rs, rc, ri);
    check("postrst_data", rd, 32'h3F80_0000);
    check("postrst_cnt", rc, 2);

    // Counter (and index) saturation on a long packet
    q = {};
    for (int i = 0; i < 260; i++) q.push_back((i == 258) ? 32'h3F80_0000 : 32'h4000_0000);
    run_pkt(q, 1'b0, 1'b0, 0, rd, rs, rc, ri);
    check("sat_cnt", rc, 255);
    check("sat_data", rd, 32'h3F80_0000);
`ifdef FP_MINMAX_IDX_EN
    check("sat_idx", ri, 255);
`endif

    // Randomised packets drawn from special values, repeats and random bit patterns
    pool = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
             32'h7F80_0001, 32'hFFC0_0123, 32'h0000_0001, 32'h8000_0001, 32'h3F80_0000,
             32'hBF80_0000, 32'h007F_FFFF, 32'hFFA0_0000};
    for (int p = 0; p < 60; p++) begin
      q = {};
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 2))
          0: q.push_back(pool[$urandom_range(0, pool.size() - 1)]);
          1: q.push_back((i > 0) ? q[$urandom_range(0, i - 1)] : 32'h3F80_0000);
          default: q.push_back($urandom);
        endcase
      end
      run_pkt(q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              rd, rs, rc, ri);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
